// File: rtl/id_stage_fwd_pkg.sv
// Shared decode constants and instruction-class predicates for the ID stage
// of the 16-bit pipelined CPU.
package id_stage_fwd_pkg;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_SLL   = 5'b00100;
  localparam logic [4:0] OP_SLA   = 5'b00101;
  localparam logic [4:0] OP_SRL   = 5'b00110;
  localparam logic [4:0] OP_SRA   = 5'b00111;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_SUB   = 5'b01010;
  localparam logic [4:0] OP_SUBI  = 5'b01011;
  localparam logic [4:0] OP_CMP   = 5'b01100;
  localparam logic [4:0] OP_AND   = 5'b01101;
  localparam logic [4:0] OP_OR    = 5'b01110;
  localparam logic [4:0] OP_XOR   = 5'b01111;
  localparam logic [4:0] OP_LDIH  = 5'b10000;
  localparam logic [4:0] OP_ADDC  = 5'b10001;
  localparam logic [4:0] OP_SUBC  = 5'b10010;
  localparam logic [4:0] OP_JUMP  = 5'b11000;
  localparam logic [4:0] OP_JMPR  = 5'b11001;
  localparam logic [4:0] OP_BZ    = 5'b11010;
  localparam logic [4:0] OP_BNZ   = 5'b11011;
  localparam logic [4:0] OP_BN    = 5'b11100;
  localparam logic [4:0] OP_BNN   = 5'b11101;
  localparam logic [4:0] OP_BC    = 5'b11110;
  localparam logic [4:0] OP_BNC   = 5'b11111;

  localparam logic [15:0] NOP_IR = 16'h0000;
  localparam logic        EXEC   = 1'b1;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_EX,
    FWD_MEM
  } fwd_sel_e;

  function automatic logic is_branch(input logic [4:0] op);
    return op inside {OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC};
  endfunction

  function automatic logic is_shift(input logic [4:0] op);
    return op inside {OP_SLL, OP_SLA, OP_SRL, OP_SRA};
  endfunction

  function automatic logic uses_ra_hi(input logic [4:0] op);
    return is_branch(op) || (op inside {OP_JMPR, OP_ADDI, OP_SUBI, OP_LDIH});
  endfunction

  function automatic logic uses_rb(input logic [4:0] op);
    return op inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR};
  endfunction

  function automatic logic uses_ra_lo(input logic [4:0] op);
    return (op inside {OP_LOAD, OP_STORE}) || is_shift(op) || uses_rb(op);
  endfunction

  function automatic logic is_store(input logic [4:0] op);
    return op == OP_STORE;
  endfunction

  function automatic logic imm4(input logic [4:0] op);
    return (op inside {OP_LOAD, OP_STORE}) || is_shift(op);
  endfunction

  function automatic logic imm8(input logic [4:0] op);
    return is_branch(op) || (op inside {OP_JUMP, OP_JMPR, OP_ADDI, OP_SUBI});
  endfunction

  function automatic logic immhi(input logic [4:0] op);
    return op == OP_LDIH;
  endfunction

endpackage

// File: rtl/id_stage_fwd_hazard.sv
// id_hazard: source usage, address match, stall and forward selects for the
// A, B and store operands. ID_FORWARD_EN enables EX/MEM forwarding.
module id_hazard
  import id_stage_fwd_pkg::*;
#(
  parameter int RA_W = 3
) (
  input  logic [4:0]      i_op,
  input  logic [RA_W-1:0] i_ra_hi,
  input  logic [RA_W-1:0] i_ra_lo,
  input  logic [RA_W-1:0] i_rb,
  input  logic            i_ex_wr_en,
  input  logic            i_ex_is_load,
  input  logic [2:0]      i_ex_wr_addr,
  input  logic            i_mem_wr_en,
  input  logic [2:0]      i_mem_wr_addr,
  output logic            o_stall,
  output fwd_sel_e        o_sel_a,
  output fwd_sel_e        o_sel_b,
  output fwd_sel_e        o_sel_s
);

  // Index 0: A operand, 1: B operand, 2: store data.
  logic [RA_W-1:0] w_src [3];
  logic [2:0]      w_used;
  logic [2:0]      w_ex_load_hit;
  logic [2:0]      w_ex_alu_hit;
  logic [2:0]      w_mem_hit;

  always_comb begin
    w_src[0] = uses_ra_hi(i_op) ? i_ra_hi : i_ra_lo;
    w_src[1] = i_rb;
    w_src[2] = i_ra_hi;
    w_used   = {is_store(i_op), uses_rb(i_op), uses_ra_hi(i_op) | uses_ra_lo(i_op)};
    for (int k = 0; k < 3; k++) begin
      w_ex_load_hit[k] = w_used[k] && i_ex_wr_en && i_ex_is_load
                         && (i_ex_wr_addr[RA_W-1:0] == w_src[k]);
      w_ex_alu_hit[k]  = w_used[k] && i_ex_wr_en && !i_ex_is_load
                         && (i_ex_wr_addr[RA_W-1:0] == w_src[k]);
      w_mem_hit[k]     = w_used[k] && i_mem_wr_en
                         && (i_mem_wr_addr[RA_W-1:0] == w_src[k]);
    end
  end

`ifdef ID_FORWARD_EN
  function automatic fwd_sel_e pick(input logic ex_hit, input logic mem_hit);
    if (ex_hit)       return FWD_EX;
    else if (mem_hit) return FWD_MEM;
    else              return FWD_RF;
  endfunction

  // A load result only exists after MEM, so only load-use needs a bubble.
  assign o_stall = |w_ex_load_hit;
  assign o_sel_a = pick(w_ex_alu_hit[0], w_mem_hit[0]);
  assign o_sel_b = pick(w_ex_alu_hit[1], w_mem_hit[1]);
  assign o_sel_s = pick(w_ex_alu_hit[2], w_mem_hit[2]);
`else
  // Without bypass every in-flight writer must retire to the register file.
  assign o_stall = |{w_ex_load_hit, w_ex_alu_hit, w_mem_hit};
  assign o_sel_a = FWD_RF;
  assign o_sel_b = FWD_RF;
  assign o_sel_s = FWD_RF;
`endif

endmodule

// File: rtl/id_stage_fwd.sv
// Decode/operand-fetch stage: handshake, flush, load-use bubbles and operand
// latching into EX. Define ID_FORWARD_EN to add EX/MEM result forwarding.
module id_stage_fwd
  import id_stage_fwd_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   state,
  input  logic                   flush,
  input  logic                   id_valid,
  input  logic [15:0]            id_ir,
  output logic                   id_ready,
  input  logic [DATA_W*NREG-1:0] gr_flat,
  input  logic                   ex_wr_en,
  input  logic                   ex_is_load,
  input  logic [2:0]             ex_wr_addr,
  input  logic [DATA_W-1:0]      ex_result,
  input  logic                   mem_wr_en,
  input  logic [2:0]             mem_wr_addr,
  input  logic [DATA_W-1:0]      mem_result,
  output logic                   ex_valid,
  output logic [15:0]            ex_ir,
  output logic [DATA_W-1:0]      reg_A,
  output logic [DATA_W-1:0]      reg_B,
  output logic [DATA_W-1:0]      smdr
);

  localparam int RA_W = $clog2(NREG);

  logic [4:0]        w_op;
  logic [RA_W-1:0]   w_ra_hi;
  logic [RA_W-1:0]   w_ra_lo;
  logic [RA_W-1:0]   w_rb;
  logic [RA_W-1:0]   w_src_a;
  logic [DATA_W-1:0] w_gr [NREG];
  logic              w_stall;
  logic              w_issue;
  fwd_sel_e          w_sel_a;
  fwd_sel_e          w_sel_b;
  fwd_sel_e          w_sel_s;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;
  logic [DATA_W-1:0] w_op_s;
  logic [DATA_W-1:0] w_b_nxt;

  logic              r_ex_valid;
  logic [15:0]       r_ex_ir;
  logic [DATA_W-1:0] r_reg_a;
  logic [DATA_W-1:0] r_reg_b;
  logic [DATA_W-1:0] r_smdr;

  assign w_op    = id_ir[15:11];
  assign w_ra_hi = id_ir[8 +: RA_W];
  assign w_ra_lo = id_ir[4 +: RA_W];
  assign w_rb    = id_ir[0 +: RA_W];
  assign w_src_a = uses_ra_hi(w_op) ? w_ra_hi : w_ra_lo;

  always_comb begin
    for (int i = 0; i < NREG; i++) w_gr[i] = gr_flat[i*DATA_W +: DATA_W];
  end

  id_hazard #(.RA_W(RA_W)) u_hazard (
    .i_op          (w_op),
    .i_ra_hi       (w_ra_hi),
    .i_ra_lo       (w_ra_lo),
    .i_rb          (w_rb),
    .i_ex_wr_en    (ex_wr_en),
    .i_ex_is_load  (ex_is_load),
    .i_ex_wr_addr  (ex_wr_addr),
    .i_mem_wr_en   (mem_wr_en),
    .i_mem_wr_addr (mem_wr_addr),
    .o_stall       (w_stall),
    .o_sel_a       (w_sel_a),
    .o_sel_b       (w_sel_b),
    .o_sel_s       (w_sel_s)
  );

  function automatic logic [DATA_W-1:0] fwd_mux(input fwd_sel_e sel,
                                                input logic [DATA_W-1:0] rf,
                                                input logic [DATA_W-1:0] ex,
                                                input logic [DATA_W-1:0] mem);
    case (sel)
      FWD_EX:  return ex;
      FWD_MEM: return mem;
      default: return rf;
    endcase
  endfunction

  assign w_op_a = fwd_mux(w_sel_a, w_gr[w_src_a], ex_result, mem_result);
  assign w_op_b = fwd_mux(w_sel_b, w_gr[w_rb],    ex_result, mem_result);
  assign w_op_s = fwd_mux(w_sel_s, w_gr[w_ra_hi], ex_result, mem_result);

  // NOTE: hold value is the default assignment, so no path leaves w_b_nxt unassigned (no latch).
  always_comb begin
    w_b_nxt = r_reg_b;
    if (imm4(w_op))       w_b_nxt = DATA_W'(id_ir[3:0]);
    else if (immhi(w_op)) w_b_nxt = DATA_W'({id_ir[7:0], 8'h00});
    else if (imm8(w_op))  w_b_nxt = DATA_W'(id_ir[7:0]);
    else if (uses_rb(w_op)) w_b_nxt = w_op_b;
  end

  // Ready ignores id_valid so the upstream handshake has no combinational loop.
  assign id_ready = (state == EXEC) && !w_stall && !flush;
  assign w_issue  = id_ready && id_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ex_valid <= 1'b0;
      r_ex_ir    <= NOP_IR;
      r_reg_a    <= '0;
      r_reg_b    <= '0;
      r_smdr     <= '0;
    end else if (state == EXEC) begin
      if (w_issue) begin
        r_ex_valid <= 1'b1;
        r_ex_ir    <= id_ir;
        r_reg_b    <= w_b_nxt;
        if (uses_ra_hi(w_op) || uses_ra_lo(w_op)) r_reg_a <= w_op_a;
        if (is_store(w_op))                       r_smdr  <= w_op_s;
      end else begin
        // Flush, stall and empty ID all insert a bubble; operands hold.
        r_ex_valid <= 1'b0;
        r_ex_ir    <= NOP_IR;
      end
    end
  end

  assign ex_valid = r_ex_valid;
  assign ex_ir    = r_ex_ir;
  assign reg_A    = r_reg_a;
  assign reg_B    = r_reg_b;
  assign smdr     = r_smdr;

endmodule

// File: tb/tb_id_stage_fwd.sv
// Self-checking bench for id_stage_fwd: vector table plus hand-written
// multi-cycle sequences, expected EX contents queued per driven cycle.
module tb_id_stage_fwd;

  logic         clock = 1'b0;
  logic         reset;
  logic         state;
  logic         flush;
  logic         id_valid;
  logic [15:0]  id_ir;
  logic         id_ready;
  logic [127:0] gr_flat;
  logic         ex_wr_en;
  logic         ex_is_load;
  logic [2:0]   ex_wr_addr;
  logic [15:0]  ex_result;
  logic         mem_wr_en;
  logic [2:0]   mem_wr_addr;
  logic [15:0]  mem_result;
  logic         ex_valid;
  logic [15:0]  ex_ir;
  logic [15:0]  reg_A;
  logic [15:0]  reg_B;
  logic [15:0]  smdr;

  logic [15:0] gr [8];
  assign gr_flat = {gr[7], gr[6], gr[5], gr[4], gr[3], gr[2], gr[1], gr[0]};

  always #5 clock = ~clock;

  id_stage_fwd #(.DATA_W(16), .NREG(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .state       (state),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_ir       (id_ir),
    .id_ready    (id_ready),
    .gr_flat     (gr_flat),
    .ex_wr_en    (ex_wr_en),
    .ex_is_load  (ex_is_load),
    .ex_wr_addr  (ex_wr_addr),
    .ex_result   (ex_result),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_result  (mem_result),
    .ex_valid    (ex_valid),
    .ex_ir       (ex_ir),
    .reg_A       (reg_A),
    .reg_B       (reg_B),
    .smdr        (smdr)
  );

  typedef struct {
    string       name;
    logic        st, fl, vld;
    logic [15:0] ir;
    logic        exw, exl;
    logic [2:0]  exa;
    logic [15:0] exr;
    logic        memw;
    logic [2:0]  mema;
    logic [15:0] memr;
    logic        rdy, ev;
    logic [15:0] eir, ea, eb, es;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t sb [$];
  vec_t tbl [13];

  function automatic vec_t mk(input string nm, input logic st, fl, vld,
                              input logic [15:0] ir, input logic exw, exl,
                              input logic [2:0] exa, input logic [15:0] exr,
                              input logic memw, input logic [2:0] mema,
                              input logic [15:0] memr, input logic rdy, ev,
                              input logic [15:0] eir, ea, eb, es);
    vec_t v;
    v.name = nm; v.st = st; v.fl = fl; v.vld = vld; v.ir = ir;
    v.exw = exw; v.exl = exl; v.exa = exa; v.exr = exr;
    v.memw = memw; v.mema = mema; v.memr = memr;
    v.rdy = rdy; v.ev = ev; v.eir = eir; v.ea = ea; v.eb = eb; v.es = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, check the combinational ready, then the EX registers after the edge.
  task automatic apply(input vec_t v);
    vec_t e;
    state = v.st; flush = v.fl; id_valid = v.vld; id_ir = v.ir;
    ex_wr_en = v.exw; ex_is_load = v.exl; ex_wr_addr = v.exa; ex_result = v.exr;
    mem_wr_en = v.memw; mem_wr_addr = v.mema; mem_result = v.memr;
    #1;
    check({v.name, " id_ready"}, 32'(id_ready), 32'(v.rdy));
    sb.push_back(v);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check({e.name, " ex_valid"}, 32'(ex_valid), 32'(e.ev));
    check({e.name, " ex_ir"},    32'(ex_ir),    32'(e.eir));
    check({e.name, " reg_A"},    32'(reg_A),    32'(e.ea));
    check({e.name, " reg_B"},    32'(reg_B),    32'(e.eb));
    check({e.name, " smdr"},     32'(smdr),     32'(e.es));
  endtask

  task automatic check_zero(input string name);
    check({name, " ex_valid"}, 32'(ex_valid), 32'h0);
    check({name, " ex_ir"},    32'(ex_ir),    32'h0);
    check({name, " reg_A"},    32'(reg_A),    32'h0);
    check({name, " reg_B"},    32'(reg_B),    32'h0);
    check({name, " smdr"},     32'(smdr),     32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    gr[0] = 16'h0000; gr[1] = 16'h1111; gr[2] = 16'h0005; gr[3] = 16'hFFFF;
    gr[4] = 16'h4444; gr[5] = 16'h5555; gr[6] = 16'h6666; gr[7] = 16'h7777;
    reset = 1'b0; state = 1'b1; flush = 1'b0; id_valid = 1'b0; id_ir = 16'h0;
    ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_wr_addr = 3'd0; ex_result = 16'h0;
    mem_wr_en = 1'b0; mem_wr_addr = 3'd0; mem_result = 16'h0;

    //                name        st fl v  ir        exw exl exa exr       mw ma mr        rdy ev eir       A         B         S
    tbl[0]  = mk("add",        1, 0, 1, 16'h4123, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h4123, 16'h0005, 16'hFFFF, 16'h0000);
    tbl[1]  = mk("addi",       1, 0, 1, 16'h495A, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h495A, 16'h1111, 16'h005A, 16'h0000);
    tbl[2]  = mk("ldih",       1, 0, 1, 16'h83AB, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h83AB, 16'hFFFF, 16'hAB00, 16'h0000);
    tbl[3]  = mk("store",      1, 0, 1, 16'h1C57, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h1C57, 16'h5555, 16'h0007, 16'h4444);
    tbl[4]  = mk("load",       1, 0, 1, 16'h167F, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h167F, 16'h7777, 16'h000F, 16'h4444);
    tbl[5]  = mk("jump",       1, 0, 1, 16'hC033, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'hC033, 16'h7777, 16'h0033, 16'h4444);
    tbl[6]  = mk("halt",       1, 0, 1, 16'h0800, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0800, 16'h7777, 16'h0033, 16'h4444);
    tbl[7]  = mk("not_exec",   0, 0, 1, 16'h4123, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0800, 16'h7777, 16'h0033, 16'h4444);
    tbl[8]  = mk("no_valid",   1, 0, 0, 16'h4123, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h7777, 16'h0033, 16'h4444);
    tbl[9]  = mk("sll",        1, 0, 1, 16'h2263, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h2263, 16'h6666, 16'h0003, 16'h4444);
    tbl[10] = mk("flush_ldih", 1, 1, 1, 16'h81AB, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h6666, 16'h0003, 16'h4444);
    tbl[11] = mk("add_nomatch",1, 0, 1, 16'h4123, 1, 0, 7, 16'hDEAD, 1, 6, 16'hBEEF, 1, 1, 16'h4123, 16'h0005, 16'hFFFF, 16'h4444);
    tbl[12] = mk("bz",         1, 0, 1, 16'hD580, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'hD580, 16'h5555, 16'h0080, 16'h4444);

    #2;
    check_zero("reset");
    @(posedge clock);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 13; i++) apply(tbl[i]);

    // Flush during a load-use stall: one bubble, stall re-evaluated next cycle.
    apply(mk("flush_stall", 1, 1, 1, 16'h5123, 1, 1, 2, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h5555, 16'h0080, 16'h4444));
    apply(mk("stall_again", 1, 0, 1, 16'h5123, 1, 1, 2, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h5555, 16'h0080, 16'h4444));
    apply(mk("stall_clear", 1, 0, 1, 16'h5123, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h5123, 16'h0005, 16'hFFFF, 16'h4444));

    // Asynchronous reset mid-cycle while a stall is pending, then release.
    id_valid = 1'b1; id_ir = 16'h5123; ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_addr = 3'd2;
    #2;
    reset = 1'b0;
    #1;
    check_zero("async_reset");
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("post_reset_stall ex_valid", 32'(ex_valid), 32'h0);
    check("post_reset_stall ex_ir",    32'(ex_ir),    32'h0);
    apply(mk("post_reset_issue", 1, 0, 1, 16'h5123, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h5123, 16'h0005, 16'hFFFF, 16'h0000));

`ifdef ID_FORWARD_EN
    apply(mk("fwd_ex_over_mem", 1, 0, 1, 16'h4123, 1, 0, 2, 16'h1234, 1, 2, 16'h9999, 1, 1, 16'h4123, 16'h1234, 16'hFFFF, 16'h0000));
    apply(mk("fwd_mem_b",       1, 0, 1, 16'h4123, 0, 0, 0, 16'h0000, 1, 3, 16'h3333, 1, 1, 16'h4123, 16'h0005, 16'h3333, 16'h0000));
    apply(mk("load_use_bubble", 1, 0, 1, 16'h5123, 1, 1, 2, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0005, 16'h3333, 16'h0000));
    apply(mk("load_use_issue",  1, 0, 1, 16'h5123, 0, 0, 0, 16'h0000, 1, 2, 16'hBEEF, 1, 1, 16'h5123, 16'hBEEF, 16'hFFFF, 16'h0000));
`else
    apply(mk("nofwd_ex_stall",  1, 0, 1, 16'h5902, 1, 0, 1, 16'hAAAA, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0005, 16'hFFFF, 16'h0000));
    apply(mk("nofwd_mem_stall", 1, 0, 1, 16'h5902, 0, 0, 0, 16'h0000, 1, 1, 16'hAAAA, 0, 0, 16'h0000, 16'h0005, 16'hFFFF, 16'h0000));
    gr[1] = 16'hAAAA;
    apply(mk("nofwd_issue",     1, 0, 1, 16'h5902, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h5902, 16'hAAAA, 16'h0002, 16'h0000));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
